// File: rtl/binning_pkg.sv
// binning_pkg: shared sequencer state type, kernel default and derived widths for the binning datapath
package binning_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, RUN} seq_state_t;
   localparam int KERNEL_SIZE_DEF = 4;
   function automatic int bin_width(input int res, input int k);
      return $clog2(res) - $clog2(k);
   endfunction
endpackage

// File: rtl/strobe_delay_line.sv
// strobe_delay_line: DEPTH-stage register shift of a packed payload, synchronous active-low reset
module strobe_delay_line #(
   parameter int DEPTH = 2,
   parameter type T = logic
) (
   input  logic clk_in,
   input  logic rst_in,
   input  T     d_in,
   output T     q_out
);
   T stage [DEPTH];
   always_ff @(posedge clk_in)
      if (!rst_in)
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      else begin
         stage[0] <= d_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   assign q_out = stage[DEPTH-1];
endmodule

// File: rtl/binning_sequencer.sv
// binning_sequencer: frame gating, one-hot line-buffer write rotation and
// read-latency-matched accumulate/emit/frame_done strobes for K x K binning
module binning_sequencer
   import binning_pkg::*;
#(
   parameter int HRES         = 1280,
   parameter int VRES         = 720,
   parameter int KERNEL_SIZE  = KERNEL_SIZE_DEF,
   parameter int READ_LATENCY = 2
) (
   input  logic                                          clk_in,
   input  logic                                          rst_in,
   input  logic                                          start_in,
   input  logic                                          stop_in,
   input  logic [$clog2(HRES)-1:0]                       hcount_in,
   input  logic [$clog2(VRES)-1:0]                       vcount_in,
   input  logic                                          data_valid_in,
   output logic [KERNEL_SIZE-1:0]                        line_we_out,
   output logic                                          acc_en_out,
   output logic                                          emit_out,
   output logic [bin_width(HRES, KERNEL_SIZE)-1:0]       hcount_out,
   output logic [bin_width(VRES, KERNEL_SIZE)-1:0]       vcount_out,
   output logic                                          frame_done_out,
   output logic                                          busy_out
);
   localparam int HW = $clog2(HRES);
   localparam int VW = $clog2(VRES);
   localparam int LK = $clog2(KERNEL_SIZE);
   localparam int BH = bin_width(HRES, KERNEL_SIZE);
   localparam int BV = bin_width(VRES, KERNEL_SIZE);

   typedef struct packed {
      logic          valid;
      logic          row_last;
      logic          col_last;
      logic          last;
      logic [BH-1:0] hbin;
      logic [BV-1:0] vbin;
   } strobe_t;

   seq_state_t state, state_nxt;
   logic stop_pending, at_origin, at_last, proc, new_row;
   logic [KERNEL_SIZE-1:0] row_ptr, row_cur;
   logic [VW-1:0] prev_v;
   strobe_t strobe_d, strobe_q;

   assign at_origin = hcount_in == '0 && vcount_in == '0;
   assign at_last   = hcount_in == HW'(HRES - 1) && vcount_in == VW'(VRES - 1);
   assign proc      = data_valid_in && (state == RUN || (state == ARMED && at_origin && !stop_in));
   assign new_row   = vcount_in != prev_v;
   // row 0 of a frame always restarts at buffer 0 rather than rotating
   assign row_cur   = (at_origin || (new_row && vcount_in == '0)) ? KERNEL_SIZE'(1) :
                      new_row ? {row_ptr[KERNEL_SIZE-2:0], row_ptr[KERNEL_SIZE-1]} : row_ptr;

   always_ff @(posedge clk_in)
      if (!rst_in) begin
         state        <= IDLE;
         stop_pending <= 1'b0;
      end else begin
         state        <= state_nxt;
         stop_pending <= state_nxt != IDLE && (stop_pending || stop_in);
      end

   always_ff @(posedge clk_in)
      if (!rst_in) begin
         row_ptr <= KERNEL_SIZE'(1);
         prev_v  <= '0;
      end else if (data_valid_in) begin
         row_ptr <= row_cur;
         prev_v  <= vcount_in;
      end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start_in ? ARMED : IDLE;
         ARMED:   state_nxt = stop_in ? IDLE : proc ? RUN : ARMED;
         RUN:     state_nxt = (data_valid_in && at_last && (stop_pending || stop_in)) ? IDLE : RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      line_we_out = proc ? row_cur : '0;
      busy_out    = state != IDLE;
   end

   assign strobe_d = '{valid:    proc,
                       row_last: &vcount_in[LK-1:0],
                       col_last: &hcount_in[LK-1:0],
                       last:     at_last,
                       hbin:     hcount_in[HW-1:LK],
                       vbin:     vcount_in[VW-1:LK]};

   strobe_delay_line #(.DEPTH(READ_LATENCY), .T(strobe_t)) u_delay (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d_in   (strobe_d),
      .q_out  (strobe_q)
   );

   assign acc_en_out     = strobe_q.valid && strobe_q.row_last;
   assign emit_out       = acc_en_out && strobe_q.col_last;
   assign hcount_out     = emit_out ? strobe_q.hbin : '0;
   assign vcount_out     = emit_out ? strobe_q.vbin : '0;
   assign frame_done_out = strobe_q.valid && strobe_q.last;
endmodule

// File: tb/tb_binning_sequencer.sv
// tb_binning_sequencer: random-gap frame stimulus checked each cycle against a behavioural model
module tb_binning_sequencer;
   localparam int HRES = 16, VRES = 8, K = 4, RL = 2;
   localparam int HW = $clog2(HRES), VW = $clog2(VRES);

   logic clk_in = 0, rst_in = 0, start_in = 0, stop_in = 0, data_valid_in = 0;
   logic [HW-1:0] hcount_in = '0;
   logic [VW-1:0] vcount_in = '0;
   logic [K-1:0] line_we_out;
   logic acc_en_out, emit_out, frame_done_out, busy_out;
   logic [HW-3:0] hcount_out;
   logic [VW-3:0] vcount_out;

   int checks = 0, errors = 0;

   binning_sequencer #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K), .READ_LATENCY(RL)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
      .hcount_in(hcount_in), .vcount_in(vcount_in), .data_valid_in(data_valid_in),
      .line_we_out(line_we_out), .acc_en_out(acc_en_out), .emit_out(emit_out),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .frame_done_out(frame_done_out),
      .busy_out(busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {bit acc; bit emit; int hb; int vb; bit done;} rec_t;
   rec_t pipe[$];
   int m_state;
   bit m_stop;
   int emit_cnt, done_cnt, done_h, done_v;
   int emit_h[$], emit_v[$];
   logic [K-1:0] we_row [VRES];
   logic [K-1:0] we_lit [K] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: 0 idle, 1 armed, 2 run; pipe holds what each beat must produce RL cycles later
   always @(negedge clk_in) begin
      rec_t r, n;
      bit proc, last;
      r = pipe[0];
      proc = data_valid_in && (m_state == 2 || (m_state == 1 && hcount_in == 0 && vcount_in == 0 && !stop_in));
      last = proc && hcount_in == HRES - 1 && vcount_in == VRES - 1;
      chk("line_we", line_we_out, proc ? (1 << (vcount_in % K)) : 0);
      chk("acc_en", acc_en_out, r.acc);
      chk("emit", emit_out, r.emit);
      if (r.emit) begin
         chk("hcount_out", hcount_out, r.hb);
         chk("vcount_out", vcount_out, r.vb);
      end
      chk("frame_done", frame_done_out, r.done);
      chk("busy", busy_out, m_state != 0);
      if (emit_out) begin
         emit_cnt++;
         emit_h.push_back(hcount_out);
         emit_v.push_back(vcount_out);
      end
      if (frame_done_out) begin
         done_cnt++;
         done_h = hcount_out;
         done_v = vcount_out;
      end
      if (proc && hcount_in == 0) we_row[vcount_in] = line_we_out;
      n.acc  = proc && vcount_in % K == K - 1;
      n.emit = n.acc && hcount_in % K == K - 1;
      n.hb   = hcount_in / K;
      n.vb   = vcount_in / K;
      n.done = last;
      void'(pipe.pop_front());
      pipe.push_back(n);
      if (!rst_in) begin
         foreach (pipe[i]) pipe[i] = '{default: 0};
         m_state = 0;
         m_stop = 0;
      end else begin
         m_stop = m_stop | stop_in;
         case (m_state)
            0: if (start_in) m_state = 1;
            1: if (stop_in) m_state = 0; else if (proc) m_state = 2;
            default: if (last && m_stop) m_state = 0;
         endcase
         if (m_state == 0) m_stop = 0;
      end
   end

   task automatic cyc(input bit v, input int h, input int vc, input bit st = 0, input bit sp = 0);
      data_valid_in = v;
      hcount_in = HW'(h);
      vcount_in = VW'(vc);
      start_in = st;
      stop_in = sp;
      @(posedge clk_in);
      #1;
      start_in = 0;
      stop_in = 0;
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) cyc(0, $urandom_range(HRES - 1), $urandom_range(VRES - 1));
   endtask

   task automatic frame(input int gap, input int stop_row = -1, input int stop_col = 0,
                        input int start_row = -1, input int rst_row = -1, input int rst_col = -1);
      for (int v = 0; v < VRES; v++)
         for (int h = 0; h < HRES; h++) begin
            while ($urandom_range(99) < gap) idle_cyc(1);
            if (v == rst_row && h == rst_col) begin
               rst_in = 0;
               cyc(1, h, v);
               rst_in = 1;
               return;
            end
            cyc(1, h, v, v == start_row && h == 0, v == stop_row && h == stop_col);
         end
   endtask

   task automatic clear_logs();
      emit_cnt = 0;
      done_cnt = 0;
      done_h = -1;
      done_v = -1;
      emit_h.delete();
      emit_v.delete();
      foreach (we_row[i]) we_row[i] = '0;
   endtask

   task automatic chk_bins(input string tag);
      chk({tag, " emits"}, emit_cnt, 8);
      for (int i = 0; i < 8; i++) begin
         chk({tag, " emit_h"}, emit_h[i], i % 4);
         chk({tag, " emit_v"}, emit_v[i], i / 4);
      end
      chk({tag, " done count"}, done_cnt, 1);
      chk({tag, " done bin h"}, done_h, 3);
      chk({tag, " done bin v"}, done_v, 1);
   endtask

   initial begin
      m_state = 0;
      m_stop = 0;
      repeat (RL) pipe.push_back('{default: 0});
      rst_in = 0;
      idle_cyc(3);
      chk("rst line_we", line_we_out, 0);
      chk("rst emit", emit_out, 0);
      chk("rst acc_en", acc_en_out, 0);
      chk("rst frame_done", frame_done_out, 0);
      chk("rst busy", busy_out, 0);
      rst_in = 1;
      idle_cyc(2);

      cyc(0, 0, 0, 1, 0);
      clear_logs();
      frame(0);
      idle_cyc(4);
      chk_bins("plain");
      for (int r = 0; r < VRES; r++) chk("row we", we_row[r], we_lit[r % K]);
      chk("plain busy", busy_out, 1);

      clear_logs();
      frame(0, 2);
      idle_cyc(4);
      chk_bins("stop row2");
      chk("stop busy", busy_out, 0);
      clear_logs();
      frame(0);
      idle_cyc(4);
      chk("ignored emits", emit_cnt, 0);
      chk("ignored done", done_cnt, 0);

      clear_logs();
      frame(0, -1, 0, 3);
      chk("midstart emits", emit_cnt, 0);
      chk("midstart armed busy", busy_out, 1);
      clear_logs();
      frame(50);
      idle_cyc(4);
      chk_bins("gapped");

      clear_logs();
      frame(0, -1, 0, -1, 7, 13);
      emit_cnt = 0;
      done_cnt = 0;
      idle_cyc(4);
      chk("rst mid emits", emit_cnt, 0);
      chk("rst mid done", done_cnt, 0);
      chk("rst mid busy", busy_out, 0);

      cyc(0, 0, 0, 1, 1);
      clear_logs();
      frame(0);
      frame(0);
      idle_cyc(4);
      chk_bins("start+stop");
      chk("start+stop busy", busy_out, 0);

      cyc(0, 0, 0, 1, 0);
      clear_logs();
      frame(0, 7, 15);
      idle_cyc(4);
      chk_bins("stop last");
      chk("stop last busy", busy_out, 0);

      for (int it = 0; it < 8; it++) begin
         cyc(0, 0, 0, 1, $urandom_range(3) == 0);
         frame($urandom_range(60), $urandom_range(2) == 0 ? $urandom_range(1, VRES - 1) : -1,
               $urandom_range(HRES - 1));
         idle_cyc($urandom_range(3));
      end
      idle_cyc(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
